// File: rtl/clock_control_input.sv
// rtl/clock_control_input.sv - front-panel STEP/MODE button conditioning for clock_module
//
// Synchronises and debounces two raw push-buttons on the free-running
// oscillator clock. An accepted STEP press produces a fixed-width adv_clk
// pulse while manual stepping is enabled; an accepted MODE press toggles
// manual_en.
//
// Ports
//   clk        free-running oscillator clock, rising edge
//   rst        synchronous active-high reset
//   step_btn   raw asynchronous STEP button (1 = pressed)
//   mode_btn   raw asynchronous MODE button (1 = pressed)
//   adv_clk    registered single-step pulse, PULSE_CYCLES wide
//   manual_en  registered manual-stepping mode level

module clock_control_input #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_WIDTH       = 16,
   parameter int PULSE_CYCLES    = 1,
   parameter bit MANUAL_AT_RESET = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic step_btn,
   input  logic mode_btn,
   output logic adv_clk,
   output logic manual_en
);

   localparam int NBTN     = 2;
   localparam int BTN_STEP = 0;
   localparam int BTN_MODE = 1;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMING,
      ST_PRESSED,
      ST_RELEASING
   } btn_state_t;

   logic [NBTN-1:0]      sync1;
   logic [NBTN-1:0]      sync2;
   btn_state_t           state_q [NBTN];
   btn_state_t           state_d [NBTN];
   logic [CNT_WIDTH-1:0] cnt_q   [NBTN];
   logic [CNT_WIDTH-1:0] cnt_d   [NBTN];
   logic [NBTN-1:0]      press_ev;
   logic [PW-1:0]        pulse_cnt;

   // Two-flop synchronisers; bit 0 is STEP, bit 1 is MODE.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {mode_btn, step_btn};
         sync2 <= sync1;
      end
   end

   // Button FSMs start in PRESSED so a button held through reset must be
   // seen released for a full debounce window before it can fire again.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NBTN; i++) begin
         if (rst) begin
            state_q[i] <= ST_PRESSED;
            cnt_q[i]   <= '0;
         end else begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // The press event is a decode of the ARMING->PRESSED transition so the
   // output registers can act on it at the very edge the FSM commits.
   always_comb begin
      press_ev = '0;
      for (int i = 0; i < NBTN; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            ST_IDLE: begin
               if (sync2[i]) begin
                  state_d[i] = ST_ARMING;
                  cnt_d[i]   = CNT_ONE;
               end
            end
            ST_ARMING: begin
               if (!sync2[i]) begin
                  state_d[i] = ST_IDLE;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i]  = ST_PRESSED;
                  cnt_d[i]    = '0;
                  press_ev[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            ST_PRESSED: begin
               if (!sync2[i]) begin
                  state_d[i] = ST_RELEASING;
                  cnt_d[i]   = CNT_ONE;
               end
            end
            ST_RELEASING: begin
               if (sync2[i]) begin
                  state_d[i] = ST_PRESSED;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i] = ST_IDLE;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            default: begin
               state_d[i] = ST_IDLE;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   // Step pulse and mode level. STEP is qualified by the pre-toggle
   // manual_en, and a pulse already running is neither extended nor cut
   // short by a mode change.
   always_ff @(posedge clk) begin
      if (rst) begin
         adv_clk   <= 1'b0;
         pulse_cnt <= '0;
         manual_en <= MANUAL_AT_RESET;
      end else begin
         if (adv_clk) begin
            if (pulse_cnt == PULSE_LAST) begin
               adv_clk   <= 1'b0;
               pulse_cnt <= '0;
            end else begin
               pulse_cnt <= pulse_cnt + 1'b1;
            end
         end else if (press_ev[BTN_STEP] && manual_en) begin
            adv_clk   <= 1'b1;
            pulse_cnt <= '0;
         end
         if (press_ev[BTN_MODE]) begin
            manual_en <= ~manual_en;
         end
      end
   end

endmodule

// File: tb/tb_clock_control_input.sv
// tb/tb_clock_control_input.sv - scoreboard bench for clock_control_input
module tb_clock_control_input;

   localparam int D = 4;
   localparam int P = 1;

   logic clk = 1'b0;
   logic rst;
   logic step_btn;
   logic mode_btn;
   logic adv_clk;
   logic manual_en;

   clock_control_input #(
      .DEBOUNCE_CYCLES(D),
      .CNT_WIDTH(16),
      .PULSE_CYCLES(P),
      .MANUAL_AT_RESET(1'b0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .step_btn(step_btn),
      .mode_btn(mode_btn),
      .adv_clk(adv_clk),
      .manual_en(manual_en)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   cyc;
      logic val;
   } ev_t;

   ev_t adv_q[$];
   ev_t man_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   int   rise_cnt     = 0;
   int   last_rise    = -1;
   int   last_fall    = -1;
   int   last_man     = -1;
   logic adv_prev     = 1'b0;
   logic man_prev     = 1'b0;
   bit   mon_en       = 1'b0;

   // Reference model: the accepted level of each button flips once the
   // synchronised input has disagreed with it for D consecutive samples.
   logic [1:0] m_s1 = '0;
   logic [1:0] m_s2 = '0;
   logic [1:0] m_lvl = 2'b11;
   int         m_run [2];
   logic       m_adv = 1'b0;
   logic       m_man = 1'b0;
   int         m_left = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic model_step();
      logic [1:0] ev;
      logic       n_adv;
      logic       n_man;
      ev_t        e;
      cyc++;
      ev    = '0;
      n_adv = m_adv;
      n_man = m_man;
      if (rst) begin
         m_s1     = '0;
         m_s2     = '0;
         m_lvl    = 2'b11;
         m_run[0] = 0;
         m_run[1] = 0;
         n_adv    = 1'b0;
         n_man    = 1'b0;
         m_left   = 0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (m_s2[b] != m_lvl[b]) begin
               m_run[b]++;
               if (m_run[b] == D) begin
                  m_lvl[b] = m_s2[b];
                  m_run[b] = 0;
                  ev[b]    = m_lvl[b];
               end
            end else begin
               m_run[b] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = {mode_btn, step_btn};
         if (m_adv) begin
            m_left--;
            if (m_left == 0) n_adv = 1'b0;
         end else if (ev[0] && m_man) begin
            n_adv  = 1'b1;
            m_left = P;
         end
         if (ev[1]) n_man = ~m_man;
      end
      if (n_adv != m_adv) begin
         e.cyc = cyc; e.val = n_adv; adv_q.push_back(e);
      end
      if (n_man != m_man) begin
         e.cyc = cyc; e.val = n_man; man_q.push_back(e);
      end
      m_adv = n_adv;
      m_man = n_man;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         model_step();
         #1;
      end
   endtask

   // Monitor: every output transition must match the next scoreboard entry.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (adv_clk !== adv_prev) begin
               if (adv_q.size() == 0) begin
                  check("adv_clk_unexpected_change", adv_clk, adv_prev);
               end else begin
                  e = adv_q.pop_front();
                  check("adv_clk_edge_cycle", cyc, e.cyc);
                  check("adv_clk_edge_value", adv_clk, e.val);
               end
               if (adv_clk === 1'b1) begin
                  rise_cnt++;
                  last_rise = cyc;
               end else begin
                  last_fall = cyc;
               end
               adv_prev = adv_clk;
            end else if (adv_q.size() > 0 && adv_q[0].cyc <= cyc) begin
               e = adv_q.pop_front();
               check("adv_clk_missing_edge", adv_clk, e.val);
            end
            if (manual_en !== man_prev) begin
               if (man_q.size() == 0) begin
                  check("manual_en_unexpected_change", manual_en, man_prev);
               end else begin
                  e = man_q.pop_front();
                  check("manual_en_edge_cycle", cyc, e.cyc);
                  check("manual_en_edge_value", manual_en, e.val);
               end
               last_man = cyc;
               man_prev = manual_en;
            end else if (man_q.size() > 0 && man_q[0].cyc <= cyc) begin
               e = man_q.pop_front();
               check("manual_en_missing_edge", manual_en, e.val);
            end
         end
      end
   end

   task automatic press_mode(input int len);
      mode_btn = 1'b1;
      tick(len);
      mode_btn = 1'b0;
      tick(10);
   endtask

   initial begin
      int r0;
      int e0;
      m_run[0] = 0;
      m_run[1] = 0;
      rst      = 1'b1;
      step_btn = 1'b0;
      mode_btn = 1'b0;
      tick(2);
      rst = 1'b0;
      check("reset_adv_clk", adv_clk, 1'b0);
      check("reset_manual_en", manual_en, 1'b0);
      mon_en = 1'b1;

      // 1: idle after reset
      r0 = rise_cnt;
      tick(20);
      check("t1_no_pulse", rise_cnt - r0, 0);

      // 2: enable manual, one step press
      press_mode(8);
      check("t2_manual_on", manual_en, 1'b1);
      r0 = rise_cnt;
      e0 = cyc + 1;
      step_btn = 1'b1;
      tick(10);
      step_btn = 1'b0;
      tick(10);
      check("t2_one_pulse", rise_cnt - r0, 1);
      check("t2_rise_edge", last_rise, e0 + D + 1);
      check("t2_fall_edge", last_fall, e0 + D + 1 + P);

      // 3: bouncing step button is rejected
      r0 = rise_cnt;
      for (int i = 0; i < 12; i++) begin
         step_btn = ~step_btn;
         tick(1);
      end
      step_btn = 1'b0;
      tick(12);
      check("t3_bounce_no_pulse", rise_cnt - r0, 0);

      // 4: manual off drops steps; mode press latency
      press_mode(8);
      check("t4_manual_off", manual_en, 1'b0);
      r0 = rise_cnt;
      step_btn = 1'b1;
      tick(10);
      step_btn = 1'b0;
      tick(10);
      check("t4_auto_no_pulse", rise_cnt - r0, 0);
      e0 = cyc + 1;
      press_mode(8);
      check("t4_mode_edge", last_man, e0 + D + 1);
      check("t4_manual_on", manual_en, 1'b1);

      // 5: step held through reset gives no event until re-pressed
      step_btn = 1'b1;
      tick(3);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      r0 = rise_cnt;
      tick(12);
      press_mode(8);
      check("t5_manual_on", manual_en, 1'b1);
      check("t5_held_no_pulse", rise_cnt - r0, 0);
      step_btn = 1'b0;
      tick(6);
      step_btn = 1'b1;
      tick(10);
      step_btn = 1'b0;
      tick(10);
      check("t5_repress_pulse", rise_cnt - r0, 1);

      // 6: simultaneous step and mode with manual on
      r0 = rise_cnt;
      step_btn = 1'b1;
      mode_btn = 1'b1;
      tick(10);
      step_btn = 1'b0;
      mode_btn = 1'b0;
      tick(10);
      check("t6_one_pulse", rise_cnt - r0, 1);
      check("t6_manual_off", manual_en, 1'b0);
      check("t6_same_edge", last_man, last_rise);

      // Randomised button activity with occasional resets
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 24) == 0) begin
            rst = 1'b1;
            tick($urandom_range(1, 2));
            rst = 1'b0;
         end else begin
            step_btn = 1'($urandom_range(0, 1));
            mode_btn = 1'($urandom_range(0, 3) == 0);
            tick($urandom_range(1, 8));
         end
      end
      step_btn = 1'b0;
      mode_btn = 1'b0;
      tick(3 * D + 10);

      check("adv_queue_drained", adv_q.size(), 0);
      check("man_queue_drained", man_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
